id_decode_stage: RTL and testbench
==================================

# id_decode_stage

Decode stage of the 16-bit, 8-register pipeline: it sits between the IF/ID register and the EX stage, directly upstream of, and wrapped around, the register file. It decodes the instruction and drives the register-file read addresses. It forwards a same-cycle write-back into the read data, detects load-use hazards (stall plus bubble), honours branch flushes, and registers everything into the ID/EX pipeline register.

## Interface
Parameters:
- DW, 16, datapath width
- AW, 3, register address width (8 registers, r0 hardwired to zero)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- if_id_instr  in  16  instruction from IF/ID
- if_id_pc  in  16  PC+1 of that instruction
- if_id_valid  in  1  IF/ID holds a real instruction
- flush  in  1  branch/jump taken in EX; squash the instruction in ID
- rf_rd_addr1, rf_rd_addr2  out  AW  register-file read addresses (rs, rt), combinational from if_id_instr
- rf_rd_data1, rf_rd_data2  in  DW  register-file read data (combinational)
- wb_wr_en, wb_wr_dest, wb_wr_data  in  1/AW/DW  write-back port, same signals that drive the register file
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- id_ex_valid, id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  1/16/DW/DW/DW  registered operands; imm is already extended
- id_ex_rs, id_ex_rt, id_ex_dest  out  AW each  registered register numbers
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch, id_ex_jump, id_ex_illegal  out  1 each  registered control
- id_ex_alu_op  out  3  registered ALU operation
- stall_count  out  16  saturating count of load-use stall cycles

## Operation
- Instruction fields: op = [15:12], rs = [11:9], rt = [8:6], rd = [5:3], funct = [2:0], imm6 = [5:0], target = [11:0].
- Decode rules:
  - 0000 R-type: reads rs and rt; dest = rd; reg_write = 1; alu_op = funct.
  - 0001 ADDI: reads rs; dest = rt; alu_src = 1; reg_write = 1; alu_op = 000.
  - 0010 LW: same as ADDI, plus mem_read = 1 and mem_to_reg = 1.
  - 0011 SW: reads rs and rt; mem_write = 1; alu_src = 1; alu_op = 000; dest = 0.
  - 0100 BEQ: reads rs and rt; branch = 1; alu_op = 001 (sub); dest = 0.
  - 0101 JMP: reads nothing; jump = 1; imm = zero-extended target.
  - Any other opcode: all control 0; illegal = 1; valid passes through.
- imm for opcodes 0001–0100: imm6 sign-extended to DW.
- A dest of 0 forces reg_write to 0.
- Operand read:
  - Address 0 reads 0.
  - Otherwise, if wb_wr_en and wb_wr_dest equals the address, the operand is wb_wr_data (write-back bypass).
  - Otherwise the operand is the register-file data.
- Load-use hazard: id_ex_valid & id_ex_mem_read & id_ex_dest != 0 & if_id_valid, and id_ex_dest equals a register the ID instruction actually reads.
  - On a hazard (and flush = 0): stall = 1, ID/EX loads a bubble, and stall_count increments (saturating at 0xFFFF).
- Flush takes priority: ID/EX loads a bubble and stall = 0, regardless of any hazard.
- Bubble: valid = 0, all control and illegal = 0; data fields are don't-care but are driven to 0.
- if_id_valid = 0 also produces a bubble.

## Timing
- Latency is one cycle: the instruction presented in cycle N appears on id_ex_* after the rising edge ending cycle N.
- stall and rf_rd_addr* are combinational within the same cycle. stall lasts exactly one cycle per load-use, because the next ID/EX content is a bubble.
- The bypass is evaluated in the same cycle as the write: the register file commits at that edge, so the bypass covers that cycle's read.
- Reset (rst_n low, asynchronous):
  - All id_ex_* outputs = 0.
  - stall_count = 0.
  - stall = 0 while reset is held (force it low).
  - Release is synchronous to the next clk edge in effect; the first valid output appears one cycle after the first post-reset valid instruction.
- Reset asserted mid-stall: the bubble and stall clear immediately, and stall_count returns to 0.

## Test plan
- Reset, then ADDI r1,r0,-3 (0x107D) -> next cycle id_ex_valid = 1, imm = 0xFFFD, dest = 1, reg_write = 1, alu_src = 1, rs_data = 0.
- LW r2,0(r1), then ADD r3,r2,r1 -> stall = 1 for one cycle, id_ex bubble (valid = 0), the ADD issues the following cycle, stall_count = 1.
- Write-back r4 = 0x1234 in the same cycle that ID reads r4, with the register file still holding the old value -> id_ex_rs_data = 0x1234. A write-back to r0 of 0xFFFF -> operand stays 0.
- LW-use hazard and flush asserted together -> stall = 0, bubble loaded, stall_count unchanged.
- Opcode 0xF, then JMP 0x5ABC -> first gives illegal = 1 with reg_write = 0; JMP gives jump = 1, imm = 0x0ABC.
- Drive 70000 consecutive load-use hazards -> stall_count saturates at 0xFFFF. Pulse rst_n low asynchronously -> every output reads 0 before the next clk edge.

Source files
------------

// File: rtl/id_decode_stage_if.sv
// Signal bundle between the decode stage and its surroundings: IF/ID input,
// register-file read port, write-back bypass and the ID/EX pipeline register.
interface id_decode_stage_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic [15:0]   if_id_instr;
  logic [15:0]   if_id_pc;
  logic          if_id_valid;
  logic          flush;
  logic [AW-1:0] rf_rd_addr1;
  logic [AW-1:0] rf_rd_addr2;
  logic [DW-1:0] rf_rd_data1;
  logic [DW-1:0] rf_rd_data2;
  logic          wb_wr_en;
  logic [AW-1:0] wb_wr_dest;
  logic [DW-1:0] wb_wr_data;
  logic          stall;
  logic          id_ex_valid;
  logic [15:0]   id_ex_pc;
  logic [DW-1:0] id_ex_rs_data;
  logic [DW-1:0] id_ex_rt_data;
  logic [DW-1:0] id_ex_imm;
  logic [AW-1:0] id_ex_rs;
  logic [AW-1:0] id_ex_rt;
  logic [AW-1:0] id_ex_dest;
  logic          id_ex_reg_write;
  logic          id_ex_mem_read;
  logic          id_ex_mem_write;
  logic          id_ex_mem_to_reg;
  logic          id_ex_alu_src;
  logic          id_ex_branch;
  logic          id_ex_jump;
  logic          id_ex_illegal;
  logic [2:0]    id_ex_alu_op;
  logic [15:0]   stall_count;

  modport master (
    output if_id_instr, if_id_pc, if_id_valid, flush,
    output rf_rd_data1, rf_rd_data2,
    output wb_wr_en, wb_wr_dest, wb_wr_data,
    input  rf_rd_addr1, rf_rd_addr2, stall,
    input  id_ex_valid, id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    input  id_ex_rs, id_ex_rt, id_ex_dest,
    input  id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
    input  id_ex_alu_src, id_ex_branch, id_ex_jump, id_ex_illegal, id_ex_alu_op,
    input  stall_count
  );

  modport slave (
    input  if_id_instr, if_id_pc, if_id_valid, flush,
    input  rf_rd_data1, rf_rd_data2,
    input  wb_wr_en, wb_wr_dest, wb_wr_data,
    output rf_rd_addr1, rf_rd_addr2, stall,
    output id_ex_valid, id_ex_pc, id_ex_rs_data, id_ex_rt_data, id_ex_imm,
    output id_ex_rs, id_ex_rt, id_ex_dest,
    output id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg,
    output id_ex_alu_src, id_ex_branch, id_ex_jump, id_ex_illegal, id_ex_alu_op,
    output stall_count
  );
endinterface

// File: rtl/id_decode_stage.sv
// Decode stage of the 16-bit, 8-register pipeline: decode, register read with
// write-back bypass, load-use stall, flush handling and the ID/EX register.
module id_decode_stage #(
  parameter int          DW        = 16,
  parameter int          AW        = 3,
  parameter logic [15:0] STALL_MAX = 16'hFFFF
) (
  input logic              clk,
  input logic              rst_n,
  id_decode_stage_if.slave bus
);

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0,
    OP_ADDI  = 4'h1,
    OP_LW    = 4'h2,
    OP_SW    = 4'h3,
    OP_BEQ   = 4'h4,
    OP_JMP   = 4'h5
  } opcode_e;

  typedef struct packed {
    logic          valid;
    logic [15:0]   pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dest;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          alu_src;
    logic          branch;
    logic          jump;
    logic          illegal;
    logic [2:0]    alu_op;
  } id_ex_t;

  logic [3:0]    op_f;
  logic [AW-1:0] rs_f, rt_f, rd_f;
  logic [2:0]    funct_f;
  logic [5:0]    imm6_f;
  logic [11:0]   target_f;

  assign op_f     = bus.if_id_instr[15:12];
  assign rs_f     = bus.if_id_instr[11:9];
  assign rt_f     = bus.if_id_instr[8:6];
  assign rd_f     = bus.if_id_instr[5:3];
  assign funct_f  = bus.if_id_instr[2:0];
  assign imm6_f   = bus.if_id_instr[5:0];
  assign target_f = bus.if_id_instr[11:0];

  assign bus.rf_rd_addr1 = rs_f;
  assign bus.rf_rd_addr2 = rt_f;

  // Operand read: r0 is zero, then the same-cycle write-back wins over the
  // register file, which only commits that value at the coming edge.
  logic [DW-1:0] rs_val, rt_val;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    rs_val = bus.rf_rd_data1;
    rt_val = bus.rf_rd_data2;
    if (rs_f == '0)                                     rs_val = '0;
    else if (bus.wb_wr_en && (bus.wb_wr_dest == rs_f)) rs_val = bus.wb_wr_data;
    if (rt_f == '0)                                     rt_val = '0;
    else if (bus.wb_wr_en && (bus.wb_wr_dest == rt_f)) rt_val = bus.wb_wr_data;
  end

  id_ex_t dec;
  logic   reads_rs, reads_rt;

  always_comb begin
    dec       = '0;
    reads_rs  = 1'b0;
    reads_rt  = 1'b0;
    dec.valid = 1'b1;
    dec.pc    = bus.if_id_pc;
    case (op_f)
      OP_RTYPE: begin
        reads_rs      = 1'b1;
        reads_rt      = 1'b1;
        dec.dest      = rd_f;
        dec.reg_write = 1'b1;
        dec.alu_op    = funct_f;
      end
      OP_ADDI, OP_LW: begin
        reads_rs       = 1'b1;
        dec.dest       = rt_f;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.imm        = {{(DW-6){imm6_f[5]}}, imm6_f};
        dec.mem_read   = (op_f == OP_LW);
        dec.mem_to_reg = (op_f == OP_LW);
      end
      OP_SW: begin
        reads_rs      = 1'b1;
        reads_rt      = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = {{(DW-6){imm6_f[5]}}, imm6_f};
      end
      OP_BEQ: begin
        reads_rs   = 1'b1;
        reads_rt   = 1'b1;
        dec.branch = 1'b1;
        dec.alu_op = 3'b001;
        dec.imm    = {{(DW-6){imm6_f[5]}}, imm6_f};
      end
      OP_JMP: begin
        dec.jump = 1'b1;
        dec.imm  = {{(DW-12){1'b0}}, target_f};
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.dest == '0) dec.reg_write = 1'b0;
    // Unread operand slots are zeroed so EX never forwards into a phantom source.
    dec.rs      = reads_rs ? rs_f   : '0;
    dec.rt      = reads_rt ? rt_f   : '0;
    dec.rs_data = reads_rs ? rs_val : '0;
    dec.rt_data = reads_rt ? rt_val : '0;
  end

  id_ex_t      id_ex_q, id_ex_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        load_use, stall_raw;

  assign load_use = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.dest != '0) &&
                    bus.if_id_valid &&
                    ((reads_rs && (rs_f == id_ex_q.dest)) ||
                     (reads_rt && (rt_f == id_ex_q.dest)));
  assign stall_raw = load_use && !bus.flush;
  assign bus.stall = stall_raw && rst_n;

  always_comb begin
    id_ex_d     = dec;
    stall_cnt_d = stall_cnt_q;
    if (bus.flush || load_use || !bus.if_id_valid) id_ex_d = '0;
    if (stall_raw && (stall_cnt_q != STALL_MAX))   stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      id_ex_q     <= id_ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.id_ex_valid      = id_ex_q.valid;
  assign bus.id_ex_pc         = id_ex_q.pc;
  assign bus.id_ex_rs_data    = id_ex_q.rs_data;
  assign bus.id_ex_rt_data    = id_ex_q.rt_data;
  assign bus.id_ex_imm        = id_ex_q.imm;
  assign bus.id_ex_rs         = id_ex_q.rs;
  assign bus.id_ex_rt         = id_ex_q.rt;
  assign bus.id_ex_dest       = id_ex_q.dest;
  assign bus.id_ex_reg_write  = id_ex_q.reg_write;
  assign bus.id_ex_mem_read   = id_ex_q.mem_read;
  assign bus.id_ex_mem_write  = id_ex_q.mem_write;
  assign bus.id_ex_mem_to_reg = id_ex_q.mem_to_reg;
  assign bus.id_ex_alu_src    = id_ex_q.alu_src;
  assign bus.id_ex_branch     = id_ex_q.branch;
  assign bus.id_ex_jump       = id_ex_q.jump;
  assign bus.id_ex_illegal    = id_ex_q.illegal;
  assign bus.id_ex_alu_op     = id_ex_q.alu_op;
  assign bus.stall_count      = stall_cnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Self-checking bench for id_decode_stage: directed cases plus random stimulus
// compared against an instruction-level reference model.
module tb_id_decode_stage;
  localparam int          DW      = 16;
  localparam int          AW      = 3;
  localparam logic [15:0] SAT_MAX = 16'd40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_decode_stage_if #(.DW(DW), .AW(AW)) ifc ();
  id_decode_stage_if #(.DW(DW), .AW(AW)) sat_ifc ();

  id_decode_stage #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // A reduced ceiling keeps the saturation point reachable in a short run.
  id_decode_stage #(.DW(DW), .AW(AW), .STALL_MAX(SAT_MAX)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sat_ifc.slave)
  );

  logic [15:0] rf [8];

  assign ifc.rf_rd_data1     = rf[ifc.rf_rd_addr1];
  assign ifc.rf_rd_data2     = rf[ifc.rf_rd_addr2];
  assign sat_ifc.if_id_instr = ifc.if_id_instr;
  assign sat_ifc.if_id_pc    = ifc.if_id_pc;
  assign sat_ifc.if_id_valid = ifc.if_id_valid;
  assign sat_ifc.flush       = ifc.flush;
  assign sat_ifc.wb_wr_en    = ifc.wb_wr_en;
  assign sat_ifc.wb_wr_dest  = ifc.wb_wr_dest;
  assign sat_ifc.wb_wr_data  = ifc.wb_wr_data;
  assign sat_ifc.rf_rd_data1 = rf[sat_ifc.rf_rd_addr1];
  assign sat_ifc.rf_rd_data2 = rf[sat_ifc.rf_rd_addr2];

  typedef struct {
    bit          valid;
    logic [15:0] pc, rs_data, rt_data, imm;
    logic [2:0]  rs, rt, dest, alu_op;
    bit          reg_write, mem_read, mem_write, mem_to_reg;
    bit          alu_src, branch, jump, illegal;
    bit          reads_rs, reads_rt, chk_imm, chk_alu;
  } exp_t;

  exp_t        m;
  int unsigned hazards;
  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  logic [15:0] pc_ctr   = 16'h0100;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e = '{default: 0};
    return e;
  endfunction

  function automatic logic [15:0] operand(input logic [2:0] a, input logic wen,
                                          input logic [2:0] wd, input logic [15:0] wdat);
    if (a == 3'd0) return 16'h0;
    if (wen && wd == a) return wdat;
    return rf[a];
  endfunction

  // Instruction-level meaning of one IF/ID word.
  function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc, input logic wen,
                                 input logic [2:0] wd, input logic [15:0] wdat);
    exp_t        e = '{default: 0};
    int          op = int'(ins[15:12]);
    logic [15:0] simm = 16'($signed(ins[5:0]));
    e.valid = 1; e.pc = pc; e.rs = ins[11:9]; e.rt = ins[8:6];
    case (op)
      0: begin
        e.reads_rs = 1; e.reads_rt = 1; e.dest = ins[5:3]; e.reg_write = 1;
        e.alu_op = ins[2:0]; e.chk_alu = 1;
      end
      1, 2: begin
        e.reads_rs = 1; e.dest = ins[8:6]; e.alu_src = 1; e.reg_write = 1;
        e.imm = simm; e.chk_imm = 1; e.chk_alu = 1;
        e.mem_read = (op == 2); e.mem_to_reg = (op == 2);
      end
      3: begin
        e.reads_rs = 1; e.reads_rt = 1; e.mem_write = 1; e.alu_src = 1;
        e.imm = simm; e.chk_imm = 1; e.chk_alu = 1;
      end
      4: begin
        e.reads_rs = 1; e.reads_rt = 1; e.branch = 1; e.alu_op = 3'd1;
        e.imm = simm; e.chk_imm = 1; e.chk_alu = 1;
      end
      5: begin
        e.jump = 1; e.imm = {4'h0, ins[11:0]}; e.chk_imm = 1;
      end
      default: begin
        e.illegal = 1; e.chk_alu = 1;
      end
    endcase
    if (e.dest == 3'd0) e.reg_write = 0;
    e.rs_data = operand(e.rs, wen, wd, wdat);
    e.rt_data = operand(e.rt, wen, wd, wdat);
    return e;
  endfunction

  function automatic bit hazard_of(input exp_t cur, input exp_t nxt, input logic v);
    return cur.valid && cur.mem_read && cur.dest != 3'd0 && v &&
           ((nxt.reads_rs && nxt.rs == cur.dest) || (nxt.reads_rt && nxt.rt == cur.dest));
  endfunction

  function automatic logic [127:0] all_idex();
    return {43'h0, ifc.id_ex_valid, ifc.id_ex_pc, ifc.id_ex_rs_data, ifc.id_ex_rt_data,
            ifc.id_ex_imm, ifc.id_ex_rs, ifc.id_ex_rt, ifc.id_ex_dest, ifc.id_ex_reg_write,
            ifc.id_ex_mem_read, ifc.id_ex_mem_write, ifc.id_ex_mem_to_reg, ifc.id_ex_alu_src,
            ifc.id_ex_branch, ifc.id_ex_jump, ifc.id_ex_illegal, ifc.id_ex_alu_op};
  endfunction

  task automatic check_outputs(input string ctx);
    logic [15:0] sat_exp = (hazards > SAT_MAX) ? SAT_MAX : 16'(hazards);
    check({ctx, ".count"}, ifc.stall_count, 16'(hazards));
    check({ctx, ".sat_count"}, sat_ifc.stall_count, sat_exp);
    if (!m.valid) begin
      check({ctx, ".bubble"}, all_idex(), 128'h0);
      return;
    end
    check({ctx, ".valid"}, ifc.id_ex_valid, 1'b1);
    check({ctx, ".pc"}, ifc.id_ex_pc, m.pc);
    check({ctx, ".dest"}, ifc.id_ex_dest, m.dest);
    check({ctx, ".ctrl"},
          {ifc.id_ex_reg_write, ifc.id_ex_mem_read, ifc.id_ex_mem_write, ifc.id_ex_mem_to_reg,
           ifc.id_ex_alu_src, ifc.id_ex_branch, ifc.id_ex_jump, ifc.id_ex_illegal},
          {m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg,
           m.alu_src, m.branch, m.jump, m.illegal});
    if (m.chk_alu) check({ctx, ".alu_op"}, ifc.id_ex_alu_op, m.alu_op);
    if (m.chk_imm) check({ctx, ".imm"}, ifc.id_ex_imm, m.imm);
    if (m.reads_rs) begin
      check({ctx, ".rs"}, ifc.id_ex_rs, m.rs);
      check({ctx, ".rs_data"}, ifc.id_ex_rs_data, m.rs_data);
    end
    if (m.reads_rt) begin
      check({ctx, ".rt"}, ifc.id_ex_rt, m.rt);
      check({ctx, ".rt_data"}, ifc.id_ex_rt_data, m.rt_data);
    end
  endtask

  task automatic step(input logic [15:0] ins, input logic v, input logic fl, input logic wen,
                      input logic [2:0] wd, input logic [15:0] wdat, input string ctx);
    exp_t nxt;
    bit   hz;
    @(negedge clk);
    ifc.if_id_instr = ins;
    ifc.if_id_pc    = pc_ctr;
    ifc.if_id_valid = v;
    ifc.flush       = fl;
    ifc.wb_wr_en    = wen;
    ifc.wb_wr_dest  = wd;
    ifc.wb_wr_data  = wdat;
    #1;
    nxt = model(ins, pc_ctr, wen, wd, wdat);
    hz  = hazard_of(m, nxt, v);
    check({ctx, ".stall"}, ifc.stall, hz && !fl);
    check({ctx, ".rd_addr"}, {ifc.rf_rd_addr1, ifc.rf_rd_addr2}, {ins[11:9], ins[8:6]});
    if (fl || hz || !v) nxt = bubble();
    if (hz && !fl && hazards < 32'hFFFF) hazards++;
    @(posedge clk);
    #1;
    if (wen && wd != 3'd0) rf[wd] = wdat;
    m = nxt;
    check_outputs(ctx);
    pc_ctr = pc_ctr + 16'd1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0]  op;
    logic [11:0] body = 12'($urandom);
    int          pick = $urandom_range(0, 15);
    if (pick < 12) op = 4'(pick % 6);
    else           op = 4'($urandom_range(6, 15));
    if (pick < 4) body[8:6] = body[11:9];
    return {op, body};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ifc.if_id_instr = '0;
    ifc.if_id_pc    = '0;
    ifc.if_id_valid = 1'b0;
    ifc.flush       = 1'b0;
    ifc.wb_wr_en    = 1'b0;
    ifc.wb_wr_dest  = '0;
    ifc.wb_wr_data  = '0;
    rf[0] = 16'hDEAD;
    for (int i = 1; i < 8; i++) rf[i] = 16'(16'h1000 * i + 16'h0BAD);
    m       = bubble();
    hazards = 0;

    #12;
    check("reset.idex", all_idex(), 128'h0);
    check("reset.stall_cnt", {ifc.stall, ifc.stall_count}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(16'h107D, 1, 0, 0, 3'd0, 16'h0, "addi");
    check("addi.imm_const", ifc.id_ex_imm, 16'hFFFD);
    check("addi.rs_data_const", ifc.id_ex_rs_data, 16'h0000);
    check("addi.dest_const", ifc.id_ex_dest, 3'd1);

    step(16'h2280, 1, 0, 0, 3'd0, 16'h0, "lw");
    step(16'h0458, 1, 0, 0, 3'd0, 16'h0, "use_stall");
    check("use_stall.valid_const", ifc.id_ex_valid, 1'b0);
    step(16'h0458, 1, 0, 0, 3'd0, 16'h0, "use_issue");
    check("use_issue.count_const", ifc.stall_count, 16'd1);

    step(16'h1940, 1, 0, 1, 3'd4, 16'h1234, "bypass");
    check("bypass.rs_data_const", ifc.id_ex_rs_data, 16'h1234);
    step(16'h1140, 1, 0, 1, 3'd0, 16'hFFFF, "wb_r0");
    check("wb_r0.rs_data_const", ifc.id_ex_rs_data, 16'h0000);

    step(16'h2280, 1, 0, 0, 3'd0, 16'h0, "lw2");
    step(16'h0458, 1, 1, 0, 3'd0, 16'h0, "flush_hz");
    check("flush_hz.count_const", ifc.stall_count, 16'd1);

    step(16'hF123, 1, 0, 0, 3'd0, 16'h0, "illegal");
    check("illegal.flags_const", {ifc.id_ex_illegal, ifc.id_ex_reg_write}, 2'b10);
    step(16'h5ABC, 1, 0, 0, 3'd0, 16'h0, "jmp");
    check("jmp.imm_const", {ifc.id_ex_jump, ifc.id_ex_imm}, {1'b1, 16'h0ABC});
    step(16'h0458, 0, 0, 0, 3'd0, 16'h0, "invalid");

    for (int i = 0; i < 50; i++) begin
      step(16'h2480, 1, 0, 0, 3'd0, 16'h0, "sat_lw");
      step(16'h0458, 1, 0, 0, 3'd0, 16'h0, "sat_use");
    end
    check("sat.ceiling_const", sat_ifc.stall_count, SAT_MAX);
    check("sat.main_const", ifc.stall_count, 16'd51);

    for (int i = 0; i < 400; i++) begin
      step(rand_instr(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
           1'($urandom), 3'($urandom), 16'($urandom), "rand");
    end

    step(16'h2280, 1, 0, 0, 3'd0, 16'h0, "pre_rst_lw");
    @(negedge clk);
    ifc.if_id_instr = 16'h0458;
    ifc.if_id_valid = 1'b1;
    ifc.flush       = 1'b0;
    ifc.wb_wr_en    = 1'b0;
    #1;
    check("mid_stall.stall", ifc.stall, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.idex", all_idex(), 128'h0);
    check("async_rst.stall_cnt", {ifc.stall, ifc.stall_count, sat_ifc.stall_count}, 33'h0);
    m       = bubble();
    hazards = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h107D, 1, 0, 0, 3'd0, 16'h0, "post_rst");

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
